// File: rtl/uart_rx_framer.sv
// Frame parser: hunts SOF, checks length/checksum, buffers one good payload for the host.
// Latency: frm_valid rises 2 clocks after the checksum byte is popped; 2 clocks per byte fetched.
// Backpressure: while a frame is held (frm_valid && !frm_ready) no further bytes are popped.
module uart_rx_framer #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_empty,
    output logic       ld_rx_data,
    input  logic [7:0] rx_data,
    output logic       frm_valid,
    input  logic       frm_ready,
    output logic [4:0] frm_len,
    input  logic [3:0] frm_rd_addr,
    output logic [7:0] frm_rd_data,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic [7:0] frm_cnt
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic            pend_q;
    logic [4:0]      len_q;
    logic [IW-1:0]   idx_q;
    logic [7:0]      sum_q;
    logic            err_pulse_q;
    logic [1:0]      err_code_q;
    logic [7:0]      cnt_q;
    logic [7:0]      pay_buf [MAX_LEN];

    // decoded strobes from the FSM
    logic            len_we;
    logic            buf_we;
    logic            err_set;
    logic [1:0]      err_val;
    logic            accept;

    // byte-level helpers; a byte is present in rx_data exactly when pend_q is set
    logic            len_ok;
    logic            last_byte;
    logic [7:0]      sum_next;

    assign len_ok    = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));
    assign last_byte = (5'(idx_q) == (len_q - 5'd1));
    assign sum_next  = sum_q + rx_data;

    // One pop in flight at most, and none while a frame waits for the host
    assign ld_rx_data  = !rx_empty && !pend_q && (state_q != S_HOLD);
    assign frm_valid   = (state_q == S_HOLD);
    assign frm_len     = len_q;
    assign frm_rd_data = pay_buf[frm_rd_addr[IW-1:0]];
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign frm_cnt     = cnt_q;

    // Parse FSM: next state and datapath strobes, advancing only on a sampled byte
    always_comb begin
        state_d = state_q;
        len_we  = 1'b0;
        buf_we  = 1'b0;
        err_set = 1'b0;
        err_val = 2'b00;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // anything other than SOF is line noise and dropped silently
                if (pend_q && (rx_data == SOF)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (pend_q) begin
                    if (len_ok) begin
                        len_we  = 1'b1;
                        state_d = S_PAYLOAD;
                    end else begin
                        err_set = 1'b1;
                        err_val = 2'b01;
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pend_q) begin
                    buf_we = 1'b1;
                    if (last_byte) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (pend_q) begin
                    if (sum_next == 8'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        err_set = 1'b1;
                        err_val = 2'b10;
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (frm_ready) begin
                    accept  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and frame bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            len_q       <= 5'd0;
            idx_q       <= '0;
            sum_q       <= 8'd0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            // a pop always lands one clock later, which also frees the slot
            pend_q      <= ld_rx_data;
            err_pulse_q <= err_set;
            if (err_set) begin
                err_code_q <= err_val;
            end
            if (len_we) begin
                len_q <= rx_data[4:0];
                sum_q <= rx_data;
                idx_q <= '0;
            end
            if (buf_we) begin
                sum_q <= sum_next;
                idx_q <= idx_q + 1'b1;
            end
            if (accept) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Payload storage; contents are meaningless until a frame is held, so no reset
    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            pay_buf[idx_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: RX FIFO stand-in, frame-level reference model, cycle compare.
// Latency: model tracks outputs per clock; compare on every falling edge.
// Backpressure: host ready is driven both deterministically and randomly.
module tb_uart_rx_framer;

    localparam logic [7:0] SOF = 8'hA5;

    typedef logic [7:0] bq_t[$];

    logic       clk;
    logic       rst_ni;
    logic       rx_empty;
    logic       ld_rx_data;
    logic [7:0] rx_data;
    logic       frm_valid;
    logic       frm_ready;
    logic [4:0] frm_len;
    logic [3:0] frm_rd_addr;
    logic [7:0] frm_rd_data;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] frm_cnt;

    uart_rx_framer #(.SOF(SOF), .MAX_LEN(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rx_empty   (rx_empty),
        .ld_rx_data (ld_rx_data),
        .rx_data    (rx_data),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_len    (frm_len),
        .frm_rd_addr(frm_rd_addr),
        .frm_rd_data(frm_rd_data),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .frm_cnt    (frm_cnt)
    );

    int checks = 0;
    int errors = 0;

    // bytes waiting in the UART RX FIFO
    logic [7:0] q[$];
    logic [7:0] fed_byte = 8'd0;

    // reference model state
    logic [7:0] acc[$];
    logic [7:0] m_pay [16];
    int         m_len  = 0;
    logic       m_hold = 1'b0;
    logic       m_pend = 1'b0;
    logic       m_errp = 1'b0;
    logic [1:0] m_code = 2'b00;
    logic [7:0] m_cnt  = 8'd0;
    logic       exp_ld;

    int         err_seen = 0;
    logic       stop = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push8(input logic [7:0] b);
        q.push_back(b);
    endtask

    task automatic push_list(input bq_t l);
        foreach (l[i]) q.push_back(l[i]);
    endtask

    // Build a frame from its rules: SOF, length, payload, byte that zeroes the sum
    task automatic push_frame(input int len, input int corrupt, input bit sof_in);
        logic [7:0] pay[$];
        int s;
        s = len;
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
        if (sof_in) pay[$urandom_range(0, len - 1)] = SOF;
        foreach (pay[i]) s += int'(pay[i]);
        push8(SOF);
        push8(8'(len));
        foreach (pay[i]) push8(pay[i]);
        push8(8'((256 - (s % 256) + corrupt) % 256));
    endtask

    // Feed one sampled byte into the frame-level model
    task automatic proc_byte(input logic [7:0] b);
        int s;
        acc.push_back(b);
        if (acc.size() == 1) begin
            if (b != SOF) acc.delete();
        end else if (acc.size() == 2) begin
            if (b == 8'd0 || b > 8'd16) begin
                m_errp = 1'b1;
                m_code = 2'b01;
                acc.delete();
            end
        end else if (acc.size() == int'(acc[1]) + 3) begin
            s = 0;
            for (int i = 1; i < acc.size(); i++) s += int'(acc[i]);
            if (s % 256 == 0) begin
                m_hold = 1'b1;
                m_len  = int'(acc[1]);
                for (int i = 0; i < m_len; i++) m_pay[i] = acc[i + 2];
            end else begin
                m_errp = 1'b1;
                m_code = 2'b10;
            end
            acc.delete();
        end
    endtask

    // FIFO empty flag follows the queue just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rx_empty = (q.size() == 0);
        end
    end

    // Compare against the model, advance it one clock, and serve pops
    always @(negedge clk) begin
        if (!rst_ni) begin
            acc.delete();
            q.delete();
            m_hold = 1'b0;
            m_pend = 1'b0;
            m_errp = 1'b0;
            m_code = 2'b00;
            m_cnt  = 8'd0;
            m_len  = 0;
        end else begin
            exp_ld = !rx_empty && !m_pend && !m_hold;
            chk("ld_rx_data", 32'(ld_rx_data), 32'(exp_ld));
            chk("frm_valid", 32'(frm_valid), 32'(m_hold));
            chk("err_pulse", 32'(err_pulse), 32'(m_errp));
            chk("err_code", 32'(err_code), 32'(m_code));
            chk("frm_cnt", 32'(frm_cnt), 32'(m_cnt));
            if (m_hold) begin
                chk("frm_len", 32'(frm_len), 32'(m_len));
                if (int'(frm_rd_addr) < m_len)
                    chk("frm_rd_data", 32'(frm_rd_data), 32'(m_pay[frm_rd_addr]));
            end
            if (err_pulse) err_seen++;
            m_errp = 1'b0;
            if (m_hold && frm_ready) begin
                m_hold = 1'b0;
                m_cnt  = m_cnt + 8'd1;
            end
            if (m_pend) proc_byte(fed_byte);
            m_pend = exp_ld;
            if (ld_rx_data && q.size() > 0) begin
                fed_byte = q.pop_front();
                rx_data  = fed_byte;
            end
        end
    end

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!frm_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!frm_valid) begin
            errors++;
            $display("FAIL %s: frm_valid got 0 expected 1 within 400 clocks", name);
        end
        #1;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [7:0] exp);
        frm_rd_addr = a;
        #1;
        chk("frm_rd_data literal", 32'(frm_rd_data), 32'(exp));
    endtask

    task automatic accept();
        @(posedge clk);
        #2 frm_ready = 1'b1;
        @(posedge clk);
        #2 frm_ready = 1'b0;
    endtask

    initial begin
        int good_n;
        int bad_n;
        int k;
        int n;
        rst_ni      = 1'b0;
        rx_empty    = 1'b1;
        rx_data     = 8'd0;
        frm_ready   = 1'b0;
        frm_rd_addr = 4'd0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst ld_rx_data", 32'(ld_rx_data), 32'd0);
        chk("rst frm_valid", 32'(frm_valid), 32'd0);
        chk("rst frm_len", 32'(frm_len), 32'd0);
        chk("rst err_pulse", 32'(err_pulse), 32'd0);
        chk("rst err_code", 32'(err_code), 32'd0);
        chk("rst frm_cnt", 32'(frm_cnt), 32'd0);
        @(posedge clk);
        #2 rst_ni = 1'b1;

        // good frame
        push_list('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97});
        wait_valid("good frame");
        chk("good frm_len", 32'(frm_len), 32'd3);
        rd_chk(4'd0, 8'h11);
        rd_chk(4'd1, 8'h22);
        rd_chk(4'd2, 8'h33);
        accept();
        repeat (4) @(negedge clk);
        #1;
        chk("good frm_cnt", 32'(frm_cnt), 32'd1);
        chk("good no errors", 32'(err_seen), 32'd0);

        // hunt past noise, SOF value used as checksum
        push_list('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h5A, 8'hA5});
        wait_valid("hunt frame");
        chk("hunt frm_len", 32'(frm_len), 32'd1);
        rd_chk(4'd0, 8'h5A);
        chk("hunt no errors", 32'(err_seen), 32'd0);
        accept();

        // bad lengths zero and seventeen, then a good frame
        push_list('{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h07, 8'hF8});
        wait_valid("badlen recovery frame");
        chk("badlen pulses", 32'(err_seen), 32'd2);
        chk("badlen err_code", 32'(err_code), 32'd1);
        rd_chk(4'd0, 8'h07);
        accept();

        // bad checksum, then a good frame
        push_list('{8'hA5, 8'h01, 8'h10, 8'h00});
        repeat (20) @(negedge clk);
        #1;
        chk("badsum pulses", 32'(err_seen), 32'd3);
        chk("badsum err_code", 32'(err_code), 32'd2);
        chk("badsum frm_valid", 32'(frm_valid), 32'd0);
        push_list('{8'hA5, 8'h01, 8'h42, 8'hBD});
        wait_valid("after badsum frame");
        rd_chk(4'd0, 8'h42);
        accept();

        // backpressure with a second frame queued
        push_list('{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h99, 8'hA5, 8'h01, 8'hC3, 8'h3C});
        wait_valid("backpressure frame 1");
        frm_rd_addr = 4'd1;
        repeat (50) begin
            @(negedge clk);
            #1;
            chk("bp ld_rx_data", 32'(ld_rx_data), 32'd0);
            chk("bp frm_len", 32'(frm_len), 32'd2);
            chk("bp frm_rd_data", 32'(frm_rd_data), 32'hBB);
        end
        accept();
        wait_valid("backpressure frame 2");
        rd_chk(4'd0, 8'hC3);
        accept();
        repeat (4) @(negedge clk);
        #1;
        chk("bp frm_cnt", 32'(frm_cnt), 32'd6);

        // reset in the middle of a payload
        push_list('{8'hA5, 8'h03, 8'h11, 8'h22});
        repeat (14) @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst ld_rx_data", 32'(ld_rx_data), 32'd0);
        chk("midrst frm_valid", 32'(frm_valid), 32'd0);
        chk("midrst frm_len", 32'(frm_len), 32'd0);
        chk("midrst err_pulse", 32'(err_pulse), 32'd0);
        chk("midrst err_code", 32'(err_code), 32'd0);
        chk("midrst frm_cnt", 32'(frm_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b1;
        push_list('{8'hA5, 8'h02, 8'h01, 8'h02, 8'hFB});
        wait_valid("post-reset frame");
        chk("post-reset frm_len", 32'(frm_len), 32'd2);
        rd_chk(4'd0, 8'h01);
        rd_chk(4'd1, 8'h02);
        accept();

        // random traffic, long enough for frm_cnt to wrap
        good_n = 0;
        bad_n  = 0;
        k      = err_seen;
        fork
            begin
                while (!stop) begin
                    @(posedge clk);
                    #2;
                    frm_ready   = ($urandom_range(0, 3) == 0);
                    frm_rd_addr = 4'($urandom_range(0, 15));
                end
                frm_ready = 1'b0;
            end
            begin
                while (good_n < 280) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4, 5: begin
                            push_frame($urandom_range(1, 16), 0, 1'b0);
                            good_n++;
                        end
                        6: begin
                            push_frame($urandom_range(1, 16), 0, 1'b1);
                            good_n++;
                        end
                        7: begin
                            push8(SOF);
                            push8(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255)));
                            bad_n++;
                        end
                        8: begin
                            push_frame($urandom_range(1, 16), $urandom_range(1, 255), 1'b0);
                            bad_n++;
                        end
                        default: begin
                            repeat ($urandom_range(1, 3)) begin
                                n = $urandom_range(0, 255);
                                push8((8'(n) == SOF) ? 8'h00 : 8'(n));
                            end
                        end
                    endcase
                    repeat ($urandom_range(0, 8)) @(posedge clk);
                end
                n = 0;
                while ((q.size() != 0 || m_hold || m_pend || acc.size() != 0) && n < 40000) begin
                    @(posedge clk);
                    n++;
                end
                checks++;
                if (n >= 40000) begin
                    errors++;
                    $display("FAIL random drain: %0d bytes left expected 0", q.size());
                end
                stop = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        #1;
        chk("random frm_cnt wrap", 32'(frm_cnt), 32'(8'(1 + good_n)));
        chk("random err count", 32'(err_seen), 32'(k + bad_n));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
